// File: rtl/switch_frame_recorder.sv
// Debounces two raw switches (strobe, data) and assembles start-bit framed words
// into a valid/ready holding register with sticky overflow and timeout flags.
module switch_frame_recorder #(
  parameter int unsigned DATA_W       = 15,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned TIMEOUT_CYC  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  SW,
  input  logic                        clear,
  input  logic                        frame_ready,
  output logic [DATA_W-1:0]           frame_data,
  output logic                        frame_valid,
  output logic                        overflow,
  output logic                        timeout,
  output logic                        busy,
  output logic [$clog2(DATA_W+1)-1:0] bit_count,
  output logic                        has_input,
  output logic                        next_input
);

  localparam int unsigned BC_W = $clog2(DATA_W + 1);
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned TO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned SH_W = (DATA_W > 1) ? DATA_W - 1 : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  logic [1:0]      s1_q, s2_q, db_q, db_d;
  logic [DB_W-1:0] cnt_q [2];
  logic [DB_W-1:0] cnt_d [2];
  logic            hin_dly_q;
  logic            evt, bit_in;

  state_t          state_q, state_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [SH_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] fd_q, fd_d, word;
  logic            fv_q, fv_d, ovf_q, ovf_d, to_q, to_d;
  logic [TO_W-1:0] idle_q, idle_d;
  logic            complete;

  // Per-switch debounce: a level change needs DEBOUNCE_CYC consecutive mismatching samples
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) db_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
  end

  assign evt    = db_q[0] & ~hin_dly_q;
  assign bit_in = db_q[1];
  assign word   = DATA_W'({sh_q, bit_in});

  always_comb begin
    state_d  = state_q;
    bc_d     = bc_q;
    sh_d     = sh_q;
    fd_d     = fd_q;
    fv_d     = fv_q;
    ovf_d    = ovf_q;
    to_d     = to_q;
    idle_d   = idle_q;
    complete = 1'b0;
    if (clear) begin
      state_d = IDLE;
      bc_d    = '0;
      fv_d    = 1'b0;
      ovf_d   = 1'b0;
      to_d    = 1'b0;
      idle_d  = '0;
    end else begin
      if (evt) begin
        idle_d = '0;
        case (state_q)
          IDLE: begin
            if (bit_in) begin
              state_d = COLLECT;
              bc_d    = '0;
              sh_d    = '0;
            end
          end
          COLLECT: begin
            sh_d = SH_W'(word);
            if (bc_q == BC_W'(DATA_W - 1)) begin
              complete = 1'b1;
              state_d  = IDLE;
              bc_d     = '0;
            end else begin
              bc_d = bc_q + BC_W'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end else if ((TIMEOUT_CYC > 0) && (state_q == COLLECT)) begin
        if (idle_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d = IDLE;
          bc_d    = '0;
          to_d    = 1'b1;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + TO_W'(1);
        end
      end else begin
        idle_d = '0;
      end
      // A completing word may reuse the slot being drained in the same cycle
      if (complete) begin
        if (!fv_q || frame_ready) begin
          fd_d = word;
          fv_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (fv_q && frame_ready) begin
        fv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      hin_dly_q <= 1'b0;
      state_q   <= IDLE;
      bc_q      <= '0;
      sh_q      <= '0;
      fd_q      <= '0;
      fv_q      <= 1'b0;
      ovf_q     <= 1'b0;
      to_q      <= 1'b0;
      idle_q    <= '0;
    end else begin
      s1_q      <= SW;
      s2_q      <= s1_q;
      db_q      <= db_d;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
      hin_dly_q <= db_q[0];
      state_q   <= state_d;
      bc_q      <= bc_d;
      sh_q      <= sh_d;
      fd_q      <= fd_d;
      fv_q      <= fv_d;
      ovf_q     <= ovf_d;
      to_q      <= to_d;
      idle_q    <= idle_d;
    end
  end

  assign frame_data  = fd_q;
  assign frame_valid = fv_q;
  assign overflow    = ovf_q;
  assign timeout     = to_q;
  assign busy        = (state_q == COLLECT);
  assign bit_count   = bc_q;
  assign has_input   = db_q[0];
  assign next_input  = db_q[1];

endmodule

// File: tb/tb_switch_frame_recorder.sv
// Bench for switch_frame_recorder: directed scenarios plus random frames checked
// against an event-level model of framing, slot handshake and sticky flags.
module tb_switch_frame_recorder;

  localparam int DW  = 15;
  localparam int DEB = 4;
  localparam int TO  = 20;
  localparam int BCW = $clog2(DW + 1);
  localparam int MASK = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] sw0 = 2'b00, sw1 = 2'b00;
  logic clr0 = 1'b0, clr1 = 1'b0, rdy0 = 1'b0, rdy1 = 1'b0;
  logic [DW-1:0] fd0, fd1;
  logic fv0, fv1, ovf0, ovf1, to0, to1, busy0, busy1, hin0, hin1, nin0, nin1;
  logic [BCW-1:0] bc0, bc1;

  int checks = 0;
  int failures = 0;
  bit sel = 1'b0;
  logic cur_d = 1'b0;

  int m_busy [2], m_bc [2], m_sh [2], m_valid [2], m_data [2], m_ovf [2], m_to [2];

  always #5 clk = ~clk;

  switch_frame_recorder #(.DATA_W(DW), .DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .SW(sw0), .clear(clr0), .frame_ready(rdy0),
    .frame_data(fd0), .frame_valid(fv0), .overflow(ovf0), .timeout(to0),
    .busy(busy0), .bit_count(bc0), .has_input(hin0), .next_input(nin0));

  switch_frame_recorder #(.DATA_W(DW), .DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TO)) dut1 (
    .clk(clk), .rst(rst), .SW(sw1), .clear(clr1), .frame_ready(rdy1),
    .frame_data(fd1), .frame_valid(fv1), .overflow(ovf1), .timeout(to1),
    .busy(busy1), .bit_count(bc1), .has_input(hin1), .next_input(nin1));

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic d);
    cur_d = d;
    if (sel) sw1 = {d, s};
    else     sw0 = {d, s};
  endtask

  task automatic set_rdy(input logic v);
    if (sel) rdy1 = v; else rdy0 = v;
  endtask

  task automatic set_clr(input logic v);
    if (sel) clr1 = v; else clr0 = v;
  endtask

  task automatic model_reset(input int k);
    m_busy[k] = 0; m_bc[k] = 0; m_sh[k] = 0; m_valid[k] = 0;
    m_data[k] = 0; m_ovf[k] = 0; m_to[k] = 0;
  endtask

  task automatic model_clear();
    m_busy[sel] = 0; m_bc[sel] = 0; m_valid[sel] = 0; m_ovf[sel] = 0; m_to[sel] = 0;
  endtask

  task automatic model_evt(input int b, input bit rdy);
    bit comp;
    int w;
    comp = 1'b0;
    w = 0;
    if (m_busy[sel] == 0) begin
      if (b != 0) begin m_busy[sel] = 1; m_bc[sel] = 0; m_sh[sel] = 0; end
    end else begin
      m_sh[sel] = ((m_sh[sel] << 1) | b) & MASK;
      m_bc[sel]++;
      if (m_bc[sel] == DW) begin
        comp = 1'b1; w = m_sh[sel]; m_busy[sel] = 0; m_bc[sel] = 0;
      end
    end
    if (comp) begin
      if (m_valid[sel] == 0 || rdy) begin m_data[sel] = w; m_valid[sel] = 1; end
      else m_ovf[sel] = 1;
    end else if (m_valid[sel] != 0 && rdy) begin
      m_valid[sel] = 0;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".data"},  sel ? 32'(fd1)   : 32'(fd0),   32'(m_data[sel]));
    chk({tag, ".valid"}, sel ? 32'(fv1)   : 32'(fv0),   32'(m_valid[sel]));
    chk({tag, ".ovf"},   sel ? 32'(ovf1)  : 32'(ovf0),  32'(m_ovf[sel]));
    chk({tag, ".tmo"},   sel ? 32'(to1)   : 32'(to0),   32'(m_to[sel]));
    chk({tag, ".busy"},  sel ? 32'(busy1) : 32'(busy0), 32'(m_busy[sel]));
    chk({tag, ".bc"},    sel ? 32'(bc1)   : 32'(bc0),   32'(m_bc[sel]));
  endtask

  // One clean press; mode 0 plain, 1 frame_ready in the event cycle, 2 clear in the event cycle
  task automatic press(input logic b, input int mode, input int x_hold, input int x_low);
    @(negedge clk) drive(1'b0, b);
    repeat (DEB + 2 + x_low) @(posedge clk);
    @(negedge clk) drive(1'b1, b);
    repeat (DEB + 2) @(posedge clk);
    @(negedge clk);
    chk("pre.bc",   sel ? 32'(bc1)   : 32'(bc0),   32'(m_bc[sel]));
    chk("pre.busy", sel ? 32'(busy1) : 32'(busy0), 32'(m_busy[sel]));
    chk("pre.hin",  sel ? 32'(hin1)  : 32'(hin0),  32'd1);
    chk("pre.nin",  sel ? 32'(nin1)  : 32'(nin0),  32'(b));
    if (mode == 1) set_rdy(1'b1);
    if (mode == 2) set_clr(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_rdy(1'b0);
    set_clr(1'b0);
    if (mode == 2) model_clear();
    else model_evt(int'(b), mode == 1);
    check_state("evt");
    repeat (x_hold) @(posedge clk);
    @(negedge clk) drive(1'b0, b);
  endtask

  task automatic rnd_press(input logic b, input int mode);
    press(b, mode, int'($urandom_range(1)), int'($urandom_range(1)));
  endtask

  // Strobe pulse one cycle shorter than the debounce window
  task automatic glitch();
    @(negedge clk);
    repeat (DEB + 2) @(posedge clk);
    @(negedge clk) drive(1'b1, cur_d);
    repeat (DEB - 1) @(posedge clk);
    @(negedge clk) drive(1'b0, cur_d);
    repeat (DEB + 3) @(posedge clk);
    @(negedge clk);
    chk("glitch.bc",  sel ? 32'(bc1)  : 32'(bc0),  32'(m_bc[sel]));
    chk("glitch.hin", sel ? 32'(hin1) : 32'(hin0), 32'd0);
  endtask

  task automatic send_frame(input int value, input int lead, input int last_mode, input bit glitches);
    for (int i = 0; i < lead; i++) rnd_press(1'b0, 0);
    rnd_press(1'b1, 0);
    for (int i = DW - 1; i >= 0; i--) begin
      if (glitches && $urandom_range(3) == 0) glitch();
      rnd_press(logic'((value >> i) & 1), (i == 0) ? last_mode : 0);
    end
  endtask

  task automatic accept();
    @(negedge clk) set_rdy(1'b1);
    @(posedge clk);
    @(negedge clk) set_rdy(1'b0);
    if (m_valid[sel] != 0) m_valid[sel] = 0;
    check_state("accept");
  endtask

  task automatic do_clear();
    @(negedge clk) set_clr(1'b1);
    @(posedge clk);
    @(negedge clk) set_clr(1'b0);
    model_clear();
    check_state("clear");
  endtask

  initial begin
    int v;
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    sel = 1'b0; check_state("rst0");
    sel = 1'b1; check_state("rst1");
    sel = 1'b0;
    rst = 1'b0;

    // Asynchronous reset in the middle of a frame, with a frame pending
    send_frame(int'($urandom_range(MASK, 1)), 1, 0, 1'b0);
    rnd_press(1'b1, 0);
    for (int i = 0; i < 5; i++) rnd_press(logic'($urandom_range(1)), 0);
    #2 rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    check_state("async_rst");
    chk("async_rst.hin", 32'(hin0), 32'd0);
    chk("async_rst.nin", 32'(nin0), 32'd0);
    drive(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Leading zeros, then 0x5A5A, with glitches between presses
    send_frame(32'h5A5A, 2, 0, 1'b1);
    chk("f5a5a.data", 32'(fd0), 32'h5A5A);
    accept();

    // Back-pressure
    send_frame(32'h1234, 0, 0, 1'b0);
    send_frame(32'h7FFF, 0, 0, 1'b0);
    chk("bp.data", 32'(fd0), 32'h1234);
    chk("bp.ovf",  32'(ovf0), 32'd1);
    accept();

    // Clear coinciding with an event mid-frame
    send_frame(int'($urandom_range(MASK)), 0, 0, 1'b0);
    rnd_press(1'b1, 0);
    for (int i = 0; i < 4; i++) rnd_press(logic'($urandom_range(1)), 0);
    rnd_press(1'b1, 2);
    chk("clr_evt.busy", 32'(busy0), 32'd0);
    chk("clr_evt.ovf",  32'(ovf0), 32'd0);
    do_clear();

    // Completion while the occupied slot is drained in the same cycle
    send_frame(int'($urandom_range(MASK)), 1, 0, 1'b0);
    send_frame(32'h0001, 0, 1, 1'b0);
    chk("simul.data",  32'(fd0), 32'h0001);
    chk("simul.valid", 32'(fv0), 32'd1);
    chk("simul.ovf",   32'(ovf0), 32'd0);
    accept();

    // Random frames with random ready timing
    for (int n = 0; n < 5; n++) begin
      v = int'($urandom_range(MASK));
      send_frame(v, int'($urandom_range(2)), int'($urandom_range(1)), 1'b1);
      if ($urandom_range(1) == 1) accept();
    end
    do_clear();

    // Inactivity timeout on the instance with TIMEOUT_CYC enabled
    sel = 1'b1;
    press(1'b1, 0, 0, 0);
    for (int i = 0; i < 3; i++) press(logic'($urandom_range(1)), 0, 0, 0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("tmo.early_busy", 32'(busy1), 32'd1);
    chk("tmo.early_bc",   32'(bc1),   32'd3);
    repeat (8) @(posedge clk);
    @(negedge clk);
    if (m_busy[1] != 0) begin m_busy[1] = 0; m_bc[1] = 0; m_to[1] = 1; end
    check_state("tmo");
    send_frame(32'h00FF, 0, 0, 1'b0);
    chk("tmo.frame", 32'(fd1), 32'h00FF);
    chk("tmo.valid", 32'(fv1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
